// File: rtl/conv_result_streamer_pkg.sv
// rtl/conv_result_streamer_pkg.sv - shared constants, sizing helper and FSM states
//
// Package conv_pkg: sample width, default convolve geometry, the result-count
// helper and the streamer state encoding. Imported by every file of the block.

package conv_pkg;

  localparam int SAMPLE_W            = 16;
  localparam int DEF_LEN             = 19;
  localparam int DEF_SIGNAL_LENGTH_1 = 2400;

  // Number of result samples the convolve block produces per frame.
  function automatic int out_count(input int len, input int sig_len_1);
    return len + sig_len_1 + 1;
  endfunction

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

endpackage

// File: rtl/conv_result_streamer_if.sv
// rtl/conv_result_streamer_if.sv - valid/ready sample stream interface
//
// Signals:
//   m_valid  sample valid (master -> slave)
//   m_ready  sample accept (slave -> master)
//   m_data   signed 16-bit sample
//   m_index  index of m_data within the frame
//   m_last   final sample of the frame

interface conv_result_streamer_if
  import conv_pkg::*;
#(
  parameter int IDX_W = 12
) ();

  logic                m_valid;
  logic                m_ready;
  logic [SAMPLE_W-1:0] m_data;
  logic [IDX_W-1:0]    m_index;
  logic                m_last;

  modport master (
    output m_valid,
    output m_data,
    output m_index,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    input  m_index,
    input  m_last,
    output m_ready
  );

endinterface

// File: rtl/conv_result_streamer_peak.sv
// rtl/conv_result_streamer_peak.sv - running peak magnitude of accepted samples
//
// Module peak_abs_tracker (present only when STREAM_PEAK_EN is defined).
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   i_clear   clear the peak to 0 (frame start)
//   i_en      sample on i_data was accepted this cycle
//   i_data    signed sample
//   o_peak    largest |sample| seen since the last clear, saturated to 32767

`ifdef STREAM_PEAK_EN
module peak_abs_tracker
  import conv_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                i_clear,
  input  logic                i_en,
  input  logic [SAMPLE_W-1:0] i_data,
  output logic [SAMPLE_W-1:0] o_peak
);

  localparam logic [SAMPLE_W-1:0] MOST_NEG = {1'b1, {(SAMPLE_W-1){1'b0}}};
  localparam logic [SAMPLE_W-1:0] MOST_POS = {1'b0, {(SAMPLE_W-1){1'b1}}};

  logic [SAMPLE_W-1:0] w_abs;
  logic [SAMPLE_W-1:0] r_peak;

  // Two's-complement magnitude; the most negative code has no positive
  // counterpart, so it saturates to the largest positive value.
  always_comb begin
    w_abs = i_data;
    if (i_data[SAMPLE_W-1]) begin
      if (i_data == MOST_NEG) begin
        w_abs = MOST_POS;
      end else begin
        w_abs = -i_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_peak <= '0;
    end else if (i_clear) begin
      r_peak <= '0;
    end else if (i_en && (w_abs > r_peak)) begin
      r_peak <= w_abs;
    end
  end

  assign o_peak = r_peak;

endmodule
`endif

// File: rtl/conv_result_streamer.sv
// rtl/conv_result_streamer.sv - serialises the convolve result vector onto a valid/ready stream
//
// Optional feature macro: STREAM_PEAK_EN (adds peak_abs output).
// Ports:
//   clk                  system clock, rising edge
//   rst                  asynchronous active-high reset
//   conv_done            convolve completion level; its rising edge starts a frame
//   flatten_conv_result  packed results, sample k at [k*16 +: 16], MSB ignored
//   m_if                 master stream: m_valid/m_ready/m_data/m_index/m_last
//   busy                 frame in progress
//   frame_done           one-cycle pulse after the final handshake
//   peak_abs             (STREAM_PEAK_EN) max |m_data| of the current frame

module conv_result_streamer
  import conv_pkg::*;
#(
  parameter  int LEN             = DEF_LEN,
  parameter  int SIGNAL_LENGTH_1 = DEF_SIGNAL_LENGTH_1,
  localparam int OUT_COUNT       = out_count(LEN, SIGNAL_LENGTH_1),
  localparam int IDX_W           = $clog2(OUT_COUNT)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          conv_done,
  input  logic [OUT_COUNT*SAMPLE_W:0]   flatten_conv_result,
  conv_result_streamer_if.master        m_if,
  output logic                          busy,
  output logic                          frame_done
`ifdef STREAM_PEAK_EN
  ,
  output logic [SAMPLE_W-1:0]           peak_abs
`endif
);

  localparam logic [0:0]       ST_IDLE   = IDLE;
  localparam logic [0:0]       ST_STREAM = STREAM;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(OUT_COUNT - 1);

  logic [0:0]          r_state;
  logic                r_done_q;
  logic                r_valid;
  logic                r_busy;
  logic                r_frame_done;
  logic [IDX_W-1:0]    r_index;

  logic                w_start;
  logic                w_accept_start;
  logic                w_hs;
  logic                w_last;
  logic [SAMPLE_W-1:0] w_sample;
  logic [SAMPLE_W-1:0] w_data;
  logic [SAMPLE_W-1:0] w_samples [OUT_COUNT];
  logic                w_unused_msb;

  // Slice the packed bus into samples; the current one is picked by index,
  // so the upstream vector must hold still for the whole frame.
  for (genvar k = 0; k < OUT_COUNT; k++) begin : g_slice
    assign w_samples[k] = flatten_conv_result[k*SAMPLE_W +: SAMPLE_W];
  end

  assign w_unused_msb = flatten_conv_result[OUT_COUNT*SAMPLE_W];

  assign w_sample = w_samples[r_index];

  // done_q comes out of reset high so a completion level already present at
  // reset release is not mistaken for a fresh edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_done_q <= 1'b1;
    end else begin
      r_done_q <= conv_done;
    end
  end

  assign w_start        = conv_done & ~r_done_q;
  assign w_accept_start = w_start & (r_state == ST_IDLE);
  assign w_hs           = r_valid & m_if.m_ready;
  assign w_last         = (r_index == LAST_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_valid      <= 1'b0;
      r_index      <= '0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state <= ST_STREAM;
            r_valid <= 1'b1;
            r_index <= '0;
            r_busy  <= 1'b1;
          end
        end
        ST_STREAM: begin
          // Start edges here are deliberately ignored: no queuing, no restart.
          if (w_hs) begin
            if (w_last) begin
              r_state      <= ST_IDLE;
              r_valid      <= 1'b0;
              r_busy       <= 1'b0;
              r_frame_done <= 1'b1;
              r_index      <= '0;
            end else begin
              r_index <= r_index + 1'b1;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Data reads as zero whenever no sample is offered.
  assign w_data = r_valid ? w_sample : '0;

  assign m_if.m_valid = r_valid;
  assign m_if.m_data  = w_data;
  assign m_if.m_index = r_index;
  assign m_if.m_last  = r_valid & w_last;
  assign busy         = r_busy;
  assign frame_done   = r_frame_done;

`ifdef STREAM_PEAK_EN
  peak_abs_tracker u_peak (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_accept_start),
    .i_en    (w_hs),
    .i_data  (w_data),
    .o_peak  (peak_abs)
  );
`endif

endmodule

// File: tb/tb_conv_result_streamer.sv
// tb/tb_conv_result_streamer.sv - directed and randomized checks of conv_result_streamer

module tb_conv_result_streamer;

  localparam int LEN   = 3;
  localparam int SIGL  = 4;
  localparam int N     = 8;
  localparam int IDXW  = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic           conv_done;
  logic [N*16:0]  flat;
  logic           busy;
  logic           frame_done;
  logic [15:0]    smp [N];
`ifdef STREAM_PEAK_EN
  logic [15:0]    peak_abs;
`endif

  int checks = 0;
  int errors = 0;

  conv_result_streamer_if #(.IDX_W(IDXW)) m_if ();

  conv_result_streamer #(
    .LEN             (LEN),
    .SIGNAL_LENGTH_1 (SIGL)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .conv_done           (conv_done),
    .flatten_conv_result (flat),
    .m_if                (m_if),
    .busy                (busy),
    .frame_done          (frame_done)
`ifdef STREAM_PEAK_EN
    ,
    .peak_abs            (peak_abs)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_bus();
    for (int k = 0; k < N; k++) flat[k*16 +: 16] = smp[k];
    flat[N*16] = 1'($urandom);
  endtask

  // Reference peak: largest magnitude of the frame's samples, clipped at 32767.
  function automatic int model_peak();
    int p, a;
    p = 0;
    for (int k = 0; k < N; k++) begin
      a = int'($signed(smp[k]));
      if (a < 0) a = -a;
      if (a > 32767) a = 32767;
      if (a > p) p = a;
    end
    return p;
  endfunction

  // mode: 0 ready always, 1 ready pattern 1,0,0,..., 2 random ready
  task automatic do_frame(input int mode, input bit retrig, input bit abort3);
    int  n, fd_cnt;
    bit  done, prev_wait, last_prev;
    logic [15:0]     pd;
    logic [IDXW-1:0] pi;
    n = 0; fd_cnt = 0; done = 0; prev_wait = 0; last_prev = 0; pd = '0; pi = '0;
    @(posedge clk); #1 conv_done = 1'b0; m_if.m_ready = 1'b1;
    @(posedge clk); #1 conv_done = 1'b1;
    @(negedge clk);
    chk("pre_start_valid", m_if.m_valid, 0);
    for (int c = 0; c < 200 && !done; c++) begin
      @(posedge clk); #1;
      if (abort3 && n == 4) begin
        rst = 1'b1;
        #1;
        chk("abort_valid", m_if.m_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_fd", frame_done, 0);
        repeat (2) begin
          @(negedge clk);
          chk("abort_fd_hold", frame_done, 0);
          chk("abort_valid_hold", m_if.m_valid, 0);
        end
        @(posedge clk); #1 rst = 1'b0;
        return;
      end
      case (mode)
        0: m_if.m_ready = 1'b1;
        1: m_if.m_ready = ((c % 3) == 0);
        default: m_if.m_ready = 1'($urandom);
      endcase
      if (retrig) begin
        if (c == 2) conv_done = 1'b0;
        if (c == 4) conv_done = 1'b1;
      end
      @(negedge clk);
      if (c == 0) begin
        chk("latency_valid", m_if.m_valid, 1);
        chk("first_index", m_if.m_index, 0);
        chk("first_busy", busy, 1);
`ifdef STREAM_PEAK_EN
        chk("peak_cleared", peak_abs, 0);
`endif
      end
      if (prev_wait) begin
        chk("hold_data", m_if.m_data, pd);
        chk("hold_index", m_if.m_index, pi);
        chk("hold_valid", m_if.m_valid, 1);
      end
      if (frame_done) begin
        fd_cnt++;
        chk("fd_after_last", last_prev, 1);
        chk("hs_count", n, N);
        chk("busy_after", busy, 0);
        chk("valid_after", m_if.m_valid, 0);
`ifdef STREAM_PEAK_EN
        chk("peak_final", peak_abs, model_peak());
`endif
        done = 1;
      end
      last_prev = 0;
      if (m_if.m_valid && m_if.m_ready && !done) begin
        chk("no_extra_hs", n < N, 1);
        if (n < N) begin
          chk("data", m_if.m_data, smp[n]);
          chk("index", m_if.m_index, n);
          chk("last", m_if.m_last, n == N - 1);
        end
        if (n == N - 1) last_prev = 1;
        n++;
      end
      prev_wait = m_if.m_valid && !m_if.m_ready;
      pd = m_if.m_data;
      pi = m_if.m_index;
    end
    chk("frame_completed", done, 1);
    repeat (4) begin
      @(negedge clk);
      chk("idle_valid", m_if.m_valid, 0);
      chk("idle_fd", frame_done, 0);
`ifdef STREAM_PEAK_EN
      chk("peak_stable", peak_abs, model_peak());
`endif
    end
    chk("fd_pulses", fd_cnt, 1);
  endtask

  initial begin
    rst = 1'b1;
    conv_done = 1'b1;
    m_if.m_ready = 1'b0;
    for (int k = 0; k < N; k++) smp[k] = 16'h0100 + 16'(k);
    load_bus();
    #1;
    chk("rst_valid", m_if.m_valid, 0);
    chk("rst_data", m_if.m_data, 0);
    chk("rst_index", m_if.m_index, 0);
    chk("rst_last", m_if.m_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fd", frame_done, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    m_if.m_ready = 1'b1;
    // conv_done high across reset release must not start a frame;
    // ready high with nothing offered has no effect.
    repeat (5) begin
      @(negedge clk);
      chk("no_start_valid", m_if.m_valid, 0);
      chk("no_start_busy", busy, 0);
    end

    do_frame(0, 0, 0);   // basic frame
    do_frame(1, 0, 0);   // backpressure 1,0,0,...
    do_frame(0, 1, 0);   // retrigger while busy
    do_frame(1, 1, 0);   // retrigger plus backpressure
    do_frame(0, 0, 1);   // reset after index-3 handshake
    do_frame(0, 0, 0);   // restart from index 0

    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < N; k++) smp[k] = 16'($urandom);
      load_bus();
      do_frame(2, 0, 0);
    end

    smp = '{16'd5, 16'hFED4, 16'd8000, 16'h8000, 16'd0, 16'd1, 16'd2, 16'd3};
    load_bus();
    do_frame(0, 0, 0);
    for (int k = 0; k < N; k++) smp[k] = 16'h0004;
    load_bus();
    do_frame(1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_result_streamer.md
Name: conv_result_streamer

Overview:
Downstream stage of the convolve block. Consumes its flattened result vector and completion flag, and streams results out one 16-bit sample per cycle over a valid/ready interface. This feeds the DAC/UART/FIFO side of the design. It replaces wide-bus consumption with an indexed serial stream that includes a last marker.

Parameters:
LEN, 19, filter length minus 1; matches convolve.
SIGNAL_LENGTH_1, 2400, signal length minus 1; matches convolve.
OUT_COUNT, LEN+SIGNAL_LENGTH_1+1, number of result samples per frame (derived; do not override).
IDX_W, $clog2(OUT_COUNT), width of the sample index.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
conv_done  input  1  driven from convolve is_completed; level signal.
flatten_conv_result  input  OUT_COUNT*16+1  packed results; sample k is at bits [k*16 +: 16]; the MSB bit is ignored.
m_valid  output  1  output sample valid.
m_ready  input  1  downstream accept.
m_data  output  16  signed sample, Q-format as produced upstream.
m_index  output  IDX_W  index of the current m_data, 0..OUT_COUNT-1.
m_last  output  1  high with the final sample of a frame.
busy  output  1  frame in progress.
frame_done  output  1  one-cycle pulse after the last handshake.

Behaviour:
- Reset (async, immediate): m_valid=0, m_data=0, m_index=0, m_last=0, busy=0, frame_done=0, FSM=IDLE, done_q=1.
  - done_q reset to 1 means conv_done already high out of reset does NOT start a frame.
- Trigger: start = conv_done & ~done_q. done_q registers conv_done every cycle.
- FSM states:
  - IDLE: on start, go to STREAM. Next cycle: m_valid=1, m_index=0, m_data=sample 0, busy=1. Latency from the sampled edge to first valid is 1 cycle.
  - STREAM: on (m_valid & m_ready), advance the index and load the next sample the following cycle, for back-to-back throughput of 1 sample/cycle. While m_valid & ~m_ready, m_data, m_index and m_last are held stable.
    - m_last=1 exactly when m_index==OUT_COUNT-1.
    - A handshake with m_last set goes to IDLE: m_valid=0, busy=0, and frame_done=1 for one cycle.
- Input stability: flatten_conv_result must stay stable while busy; it is read combinationally by index, with no internal copy.
- A start edge while busy is ignored (no queuing, no restart).
- m_ready may be high while m_valid=0; this has no effect.
- Reset asserted mid-frame aborts the frame. No frame_done is issued.
- Arithmetic: none on the data path. The index counter is IDX_W bits and never wraps past OUT_COUNT-1.

Optional Feature:
Macro STREAM_PEAK_EN.
- Defined:
  - Adds output peak_abs[15:0], the maximum |m_data| over handshaken samples of the current frame. |−32768| saturates to 32767.
  - peak_abs clears to 0 on start and on reset.
  - peak_abs is final and stable from the frame_done cycle until the next start.
- Undefined: the port and logic are absent. Behaviour is otherwise identical.

Decomposition:
- Package conv_pkg holds:
  - SAMPLE_W=16.
  - Default LEN and SIGNAL_LENGTH_1.
  - Function out_count(len, sig_len_1) returning len+sig_len_1+1.
  - FSM state enum {IDLE, STREAM}.
- Sub-module peak_abs_tracker: abs, saturate, max register, clear. It is instantiated only under STREAM_PEAK_EN.

Test Plan:
- Setup for all scenarios: LEN=3, SIGNAL_LENGTH_1=4 (OUT_COUNT=8, bus width 129). Sample k = 16'h0100+k.
- Scenario 1 (basic frame):
  - Stimulus: m_ready held 1; conv_done 0→1.
  - Response: m_valid rises 1 cycle after the sampled edge. m_data = 0100..0107 on consecutive cycles, with m_index 0..7. m_last only with 0107. frame_done pulses the next cycle; busy=0 afterwards.
- Scenario 2 (backpressure):
  - Stimulus: m_ready toggling 1,0,0,1,…
  - Response: each sample is held until accepted. Exactly 8 handshakes occur, in order, with no duplicates or drops.
- Scenario 3 (reset conditions):
  - Stimulus: conv_done=1 during and after reset.
  - Response: no frame starts. Dropping conv_done to 0 and raising it again starts one frame.
- Scenario 4 (retrigger while busy):
  - Stimulus: conv_done pulsed 0→1→0→1 during the stream.
  - Response: the second edge is ignored. Exactly one frame of 8 samples is produced.
- Scenario 5 (reset mid-frame):
  - Stimulus: rst asserted after handshake of index 3.
  - Response: m_valid=0 and busy=0 immediately, no frame_done. A subsequent edge streams from index 0.
- Scenario 6 (STREAM_PEAK_EN):
  - Stimulus: samples {5, −300, 8000, −32768, 0, 1, 2, 3}.
  - Response: peak_abs=32767 at frame_done. A following frame of all 16'h0004 yields peak_abs=4.
